// File: rtl/cpu19_pkg.sv
// Shared encodings for the cpu19 cycle controller: opcodes, bus sources,
// fault codes and the sequencer state set.
package cpu19_pkg;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_LDA  = 5'h01;
  localparam logic [4:0] OP_STA  = 5'h02;
  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_JMP  = 5'h04;
  localparam logic [4:0] OP_CLA  = 5'h05;
  localparam logic [4:0] OP_INCA = 5'h06;
  localparam logic [4:0] OP_HLT  = 5'h07;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_PC   = 3'd1;
  localparam logic [2:0] BUS_AR   = 3'd2;
  localparam logic [2:0] BUS_IR   = 3'd3;
  localparam logic [2:0] BUS_DR   = 3'd4;
  localparam logic [2:0] BUS_AC   = 3'd5;
  localparam logic [2:0] BUS_MEM  = 3'd6;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_ILLEGAL = 2'd1;
  localparam logic [1:0] FC_TIMEOUT = 2'd2;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_F0,
    ST_F1,
    ST_D0,
    ST_E0,
    ST_E1,
    ST_HALT,
    ST_FAULT
  } state_e;

endpackage

// File: rtl/cpu19_mem_wait_timer.sv
// Memory wait timer: cleared when a request state is entered, counts request
// cycles without an ack, and flags the last allowed request cycle.
module cpu19_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic cnt_i,
  output logic expire_o
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, saturate at the last allowed cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count value N-1 marks request cycle N; the last one is MEM_TIMEOUT.
  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/cpu19_cycle_controller.sv
// Fetch/decode/execute sequencer for the 19-bit CPU datapath. Strobes are
// decoded from the registered state plus IR opcode and memory ack, so they
// fall as soon as the state register is reset.
module cpu19_cycle_controller
  import cpu19_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic [4:0] ir_op_i,
  input  logic       mem_ack_i,
  output logic       pc_load_o,
  output logic       pc_inc_o,
  output logic       pc_clr_o,
  output logic       ar_load_o,
  output logic       ir_load_o,
  output logic       dr_load_o,
  output logic       ac_load_o,
  output logic       ac_inc_o,
  output logic       ac_clr_o,
  output logic       alu_add_o,
  output logic       mem_rd_o,
  output logic       mem_wr_o,
  output logic [2:0] bus_sel_o,
  output logic       halted_o,
  output logic       fault_o,
  output logic [1:0] fault_code_o
);

  state_e     state_q, state_d;
  logic [4:0] op_q;
  logic [1:0] fc_q, fc_d;
  logic       tmr_clr, tmr_cnt, tmr_expire;

  // A request state is being entered from elsewhere: restart the wait count.
  assign tmr_clr = ((state_d == ST_F1) && (state_q != ST_F1)) ||
                   ((state_d == ST_E0) && (state_q != ST_E0));
  assign tmr_cnt = ((state_q == ST_F1) || (state_q == ST_E0)) && !mem_ack_i;

  cpu19_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr_i    (tmr_clr),
    .cnt_i    (tmr_cnt),
    .expire_o (tmr_expire)
  );

  // Next-state and strobe decode.
  always_comb begin
    state_d   = state_q;
    fc_d      = FC_NONE;
    pc_load_o = 1'b0;
    pc_inc_o  = 1'b0;
    pc_clr_o  = 1'b0;
    ar_load_o = 1'b0;
    ir_load_o = 1'b0;
    dr_load_o = 1'b0;
    ac_load_o = 1'b0;
    ac_inc_o  = 1'b0;
    ac_clr_o  = 1'b0;
    alu_add_o = 1'b0;
    mem_rd_o  = 1'b0;
    mem_wr_o  = 1'b0;
    bus_sel_o = BUS_NONE;
    halted_o  = 1'b0;
    fault_o   = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        pc_clr_o = 1'b1;
        ac_clr_o = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_IDLE: begin
        // STOP beats START while idle.
        if (!stop_i && start_i) state_d = ST_F0;
      end
      ST_F0: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else begin
          bus_sel_o = BUS_PC;
          ar_load_o = 1'b1;
          state_d   = ST_F1;
        end
      end
      ST_F1: begin
        mem_rd_o  = 1'b1;
        bus_sel_o = BUS_MEM;
        if (mem_ack_i) begin
          ir_load_o = 1'b1;
          pc_inc_o  = 1'b1;
          state_d   = ST_D0;
        end else if (tmr_expire) begin
          fc_d    = FC_TIMEOUT;
          state_d = ST_FAULT;
        end
      end
      ST_D0: begin
        case (ir_op_i)
          OP_NOP: state_d = ST_F0;
          OP_LDA, OP_STA, OP_ADD: begin
            bus_sel_o = BUS_IR;
            ar_load_o = 1'b1;
            state_d   = ST_E0;
          end
          OP_JMP: begin
            bus_sel_o = BUS_IR;
            pc_load_o = 1'b1;
            state_d   = ST_F0;
          end
          OP_CLA: begin
            ac_clr_o = 1'b1;
            state_d  = ST_F0;
          end
          OP_INCA: begin
            ac_inc_o = 1'b1;
            state_d  = ST_F0;
          end
          OP_HLT: state_d = ST_HALT;
          default: begin
            fc_d    = FC_ILLEGAL;
            state_d = ST_FAULT;
          end
        endcase
      end
      ST_E0: begin
        // Operand access uses the opcode captured in D0.
        if (op_q == OP_STA) begin
          mem_wr_o  = 1'b1;
          bus_sel_o = BUS_AC;
        end else begin
          mem_rd_o  = 1'b1;
          bus_sel_o = BUS_MEM;
        end
        if (mem_ack_i) begin
          if (op_q == OP_STA) begin
            state_d = ST_F0;
          end else begin
            dr_load_o = 1'b1;
            state_d   = ST_E1;
          end
        end else if (tmr_expire) begin
          fc_d    = FC_TIMEOUT;
          state_d = ST_FAULT;
        end
      end
      ST_E1: begin
        bus_sel_o = BUS_DR;
        ac_load_o = 1'b1;
        alu_add_o = (op_q == OP_ADD);
        state_d   = ST_F0;
      end
      ST_HALT: begin
        halted_o = 1'b1;
        if (start_i && !stop_i) state_d = ST_F0;
      end
      ST_FAULT: begin
        fault_o = 1'b1;
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign fault_code_o = (state_q == ST_FAULT) ? fc_q : FC_NONE;

  // State, latched opcode and fault cause.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_INIT;
      op_q    <= OP_NOP;
      fc_q    <= FC_NONE;
    end else begin
      state_q <= state_d;
      if (state_q == ST_D0) op_q <= ir_op_i;
      if ((state_d == ST_FAULT) && (state_q != ST_FAULT)) fc_q <= fc_d;
    end
  end

endmodule

// File: tb/tb_cpu19_cycle_controller.sv
// Bench for cpu19_cycle_controller: drives it against a 19-bit register
// model and a small behavioural memory with programmable wait states.
module tb_cpu19_cycle_controller;
  import cpu19_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic [4:0] ir_op;
  logic       mem_ack;
  logic pc_load, pc_inc, pc_clr, ar_load, ir_load, dr_load;
  logic ac_load, ac_inc, ac_clr, alu_add, mem_rd, mem_wr;
  logic [2:0] bus_sel;
  logic       halted, fault;
  logic [1:0] fault_code;

  cpu19_cycle_controller #(.MEM_TIMEOUT(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop),
    .ir_op_i(ir_op), .mem_ack_i(mem_ack),
    .pc_load_o(pc_load), .pc_inc_o(pc_inc), .pc_clr_o(pc_clr),
    .ar_load_o(ar_load), .ir_load_o(ir_load), .dr_load_o(dr_load),
    .ac_load_o(ac_load), .ac_inc_o(ac_inc), .ac_clr_o(ac_clr),
    .alu_add_o(alu_add), .mem_rd_o(mem_rd), .mem_wr_o(mem_wr),
    .bus_sel_o(bus_sel), .halted_o(halted), .fault_o(fault),
    .fault_code_o(fault_code)
  );

  logic [11:0] strb;
  assign strb = {pc_load, pc_inc, pc_clr, ar_load, ir_load, dr_load,
                 ac_load, ac_inc, ac_clr, alu_add, mem_rd, mem_wr};
  localparam logic [11:0] STRB_INIT = 12'h208;

  // Datapath and memory model
  logic [18:0] pc, ar, ir, dr, ac, bus;
  logic [18:0] mem [64];
  logic        ack_en = 1'b1;
  int          wait_n = 0;
  int          req_cnt;
  logic        ld_en = 1'b0, ld_clr = 1'b0;
  logic [5:0]  ld_addr = '0;
  logic [18:0] ld_data = '0;

  assign ir_op   = ir[18:14];
  assign mem_ack = ack_en && (mem_rd || mem_wr) && (req_cnt == wait_n);

  always_comb begin
    bus = '0;
    case (bus_sel)
      3'd1: bus = pc;
      3'd2: bus = ar;
      3'd3: bus = {5'd0, ir[13:0]};
      3'd4: bus = dr;
      3'd5: bus = ac;
      3'd6: bus = mem[ar[5:0]];
      default: bus = '0;
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '1; ac <= '1; ar <= '0; ir <= '0; dr <= '0; req_cnt <= 0;
    end else begin
      if (pc_clr) pc <= '0;
      else if (pc_load) pc <= bus;
      else if (pc_inc) pc <= pc + 19'd1;
      if (ar_load) ar <= bus;
      if (ir_load) ir <= bus;
      if (dr_load) dr <= bus;
      if (ac_clr) ac <= '0;
      else if (ac_load) ac <= alu_add ? (ac + dr) : bus;
      else if (ac_inc) ac <= ac + 19'd1;
      if ((mem_rd || mem_wr) && !mem_ack) req_cnt <= req_cnt + 1;
      else req_cnt <= 0;
    end
  end

  always @(posedge clk) begin
    if (ld_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (mem_wr && mem_ack) begin
      mem[ar[5:0]] <= bus;
    end
  end

  // Checking infrastructure
  int total = 0;
  int bad   = 0;

  typedef struct packed { logic [18:0] addr; logic [18:0] data; } wr_t;
  wr_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle; completed memory writes are matched against the queue.
  task automatic step();
    wr_t e;
    if (rst_n && mem_wr && mem_ack) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", ar, bus);
      end else begin
        e = exp_q.pop_front();
        if (e.addr !== ar || e.data !== bus) begin
          bad++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   ar, bus, e.addr, e.data);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [18:0] ins(input logic [4:0] op, input logic [13:0] a);
    return {op, a};
  endfunction

  task automatic load_word(input logic [5:0] a, input logic [18:0] d);
    ld_addr = a; ld_data = d; ld_en = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Enter reset and load a two-word program plus data at 0x10/0x11.
  task automatic hold_reset_load(input logic [18:0] w0, input logic [18:0] w1, input int wt);
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; ack_en = 1'b1; wait_n = wt;
    #1;
    ld_clr = 1'b1;
    @(posedge clk); #1;
    ld_clr = 1'b0;
    load_word(6'h00, w0);
    load_word(6'h01, w1);
    load_word(6'h10, 19'd2349);
    load_word(6'h11, 19'd1);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    step();
  endtask

  // From IDLE, pulse START; returns in the first F0 cycle.
  task automatic begin_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_halt(input int maxc, output int cyc);
    cyc = 0;
    while (!halted && cyc < maxc) begin
      step();
      cyc++;
    end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [13:0] arg;
    int          wt;
    logic [18:0] exp_ac;
    int          exp_cyc;
    logic        exp_wr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int rd_n, il_n, pi_n, bad_idle;

    vecs[0] = '{OP_NOP,  14'h00, 0, 19'd0,    6,  1'b0};
    vecs[1] = '{OP_CLA,  14'h00, 0, 19'd0,    6,  1'b0};
    vecs[2] = '{OP_INCA, 14'h00, 0, 19'd1,    6,  1'b0};
    vecs[3] = '{OP_LDA,  14'h10, 0, 19'd2349, 8,  1'b0};
    vecs[4] = '{OP_ADD,  14'h10, 0, 19'd2349, 8,  1'b0};
    vecs[5] = '{OP_STA,  14'h12, 0, 19'd0,    7,  1'b1};
    vecs[6] = '{OP_LDA,  14'h10, 2, 19'd2349, 14, 1'b0};
    vecs[7] = '{OP_INCA, 14'h00, 1, 19'd1,    8,  1'b0};
    vecs[8] = '{OP_STA,  14'h12, 3, 19'd0,    16, 1'b1};

    // Reset state and full program LDA/ADD/STA/HLT
    hold_reset_load(ins(OP_LDA, 14'h10), ins(OP_ADD, 14'h11), 0);
    load_word(6'h02, ins(OP_STA, 14'h12));
    load_word(6'h03, ins(OP_HLT, 14'h0));
    chk("rst_strobes", 32'(strb), 32'(STRB_INIT));
    chk("rst_bus_sel", 32'(bus_sel), 32'd0);
    chk("rst_flags", 32'({halted, fault, fault_code}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_strobes", 32'(strb), 32'(STRB_INIT));
    step();
    chk("idle_strobes", 32'(strb), 32'd0);
    chk("init_pc_clr", 32'(pc), 32'd0);
    chk("init_ac_clr", 32'(ac), 32'd0);
    exp_q.push_back('{19'h12, 19'd2350});
    begin_run();
    wait_halt(100, cyc);
    chk("prog_halted", 32'(halted), 32'd1);
    chk("prog_cycles", 32'(cyc), 32'd17);
    chk("prog_ac", 32'(ac), 32'd2350);
    chk("prog_mem12", 32'(mem[6'h12]), 32'd2350);
    chk("prog_wr_done", 32'(exp_q.size()), 32'd0);

    // Single instruction followed by HLT, several wait-state settings
    for (int i = 0; i < 9; i++) begin
      hold_reset_load(ins(vecs[i].op, vecs[i].arg), ins(OP_HLT, 14'h0), vecs[i].wt);
      release_reset();
      if (vecs[i].exp_wr) exp_q.push_back('{19'h12, 19'd0});
      begin_run();
      wait_halt(200, cyc);
      chk($sformatf("vec%0d_halted", i), 32'(halted), 32'd1);
      chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      chk($sformatf("vec%0d_ac", i), 32'(ac), 32'(vecs[i].exp_ac));
      chk($sformatf("vec%0d_pc", i), 32'(pc), 32'd2);
      chk($sformatf("vec%0d_wr_done", i), 32'(exp_q.size()), 32'd0);
    end

    // JMP 5: D0 loads PC from IR field, next fetch addresses 5
    hold_reset_load(ins(OP_JMP, 14'h5), ins(OP_NOP, 14'h0), 0);
    load_word(6'h05, ins(OP_HLT, 14'h0));
    release_reset();
    begin_run();
    step();
    step();
    chk("jmp_d0_pc_load", 32'(pc_load), 32'd1);
    chk("jmp_d0_pc_inc", 32'(pc_inc), 32'd0);
    chk("jmp_d0_bus_sel", 32'(bus_sel), 32'd3);
    chk("jmp_d0_bus", 32'(bus), 32'd5);
    step();
    chk("jmp_f0_ar_load", 32'(ar_load), 32'd1);
    chk("jmp_f0_bus", 32'(bus), 32'd5);
    wait_halt(50, cyc);
    chk("jmp_cycles", 32'(cyc + 3), 32'd6);
    chk("jmp_ar", 32'(ar), 32'd5);
    chk("jmp_pc", 32'(pc), 32'd6);

    // Memory acks on the third request cycle
    hold_reset_load(ins(OP_NOP, 14'h0), ins(OP_HLT, 14'h0), 2);
    release_reset();
    begin_run();
    rd_n = 0; il_n = 0; pi_n = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      rd_n += int'(mem_rd);
      il_n += int'(ir_load);
      pi_n += int'(pc_inc);
    end
    chk("wait_rd_cycles", 32'(rd_n), 32'd3);
    chk("wait_ir_load", 32'(il_n), 32'd1);
    chk("wait_pc_inc", 32'(pi_n), 32'd1);
    chk("wait_d0_rd", 32'(mem_rd), 32'd0);

    // No ack: timeout fault after 16 request cycles
    hold_reset_load(ins(OP_NOP, 14'h0), ins(OP_HLT, 14'h0), 0);
    ack_en = 1'b0;
    release_reset();
    begin_run();
    rd_n = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      rd_n += int'(mem_rd);
    end
    chk("tmo_rd_cycles", 32'(rd_n), 32'd16);
    chk("tmo_not_yet", 32'(fault), 32'd0);
    step();
    chk("tmo_fault", 32'(fault), 32'd1);
    chk("tmo_code", 32'(fault_code), 32'd2);
    chk("tmo_rd_drop", 32'(mem_rd), 32'd0);
    for (int k = 0; k < 4; k++) begin
      start = ~start;
      stop  = (k == 1);
      step();
    end
    start = 1'b0; stop = 1'b0;
    chk("tmo_sticky", 32'({fault, fault_code}), 32'({1'b1, 2'd2}));
    chk("tmo_no_strobes", 32'(strb), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("tmo_rst_flags", 32'({fault, fault_code}), 32'd0);
    chk("tmo_rst_strobes", 32'(strb), 32'(STRB_INIT));

    // Illegal opcode 0x1F
    hold_reset_load(ins(5'h1F, 14'h0), ins(OP_HLT, 14'h0), 0);
    release_reset();
    begin_run();
    step();
    step();
    chk("ill_d0_strobes", 32'(strb), 32'd0);
    chk("ill_d0_fault", 32'(fault), 32'd0);
    step();
    chk("ill_fault", 32'(fault), 32'd1);
    chk("ill_code", 32'(fault_code), 32'd1);

    // STOP raised during E0 of an LDA
    hold_reset_load(ins(OP_LDA, 14'h10), ins(OP_HLT, 14'h0), 1);
    release_reset();
    begin_run();
    for (int k = 0; k < 4; k++) step();
    stop = 1'b1;
    chk("stop_e0_rd", 32'(mem_rd), 32'd1);
    step();
    step();
    chk("stop_e1_ac_load", 32'(ac_load), 32'd1);
    chk("stop_e1_bus_sel", 32'(bus_sel), 32'd4);
    step();
    chk("stop_f0_strobes", 32'(strb), 32'd0);
    step();
    chk("stop_ac", 32'(ac), 32'd2349);
    chk("stop_idle", 32'({strb, halted}), 32'd0);
    start = 1'b1;
    bad_idle = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (strb != 12'd0 || halted) bad_idle++;
    end
    chk("start_stop_idle", 32'(bad_idle), 32'd0);
    stop = 1'b0;
    step();
    start = 1'b0;
    chk("resume_f0_ar_load", 32'(ar_load), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
